// File: rtl/z_core_seq_divider_pkg.sv
// ----------------------------------------------------------------------------
// z_core_seq_divider_pkg
//   Shared definitions for the Z-Core sequential divider: the default operand
//   width used across the execute units and the divider FSM state encoding.
// ----------------------------------------------------------------------------
package z_core_seq_divider_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } div_state_e;

endpackage

// File: rtl/z_core_seq_divider_if.sv
// ----------------------------------------------------------------------------
// z_core_seq_divider_if
//   Request/response bundle between the execute stage and the divider.
//   master : execute stage (drives operands, start, abort)
//   slave  : divider       (drives running, done, result, div_by_zero)
// ----------------------------------------------------------------------------
interface z_core_seq_divider_if #(
    parameter int XLEN = z_core_seq_divider_pkg::XLEN_DEFAULT
);
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_start;
    logic            is_signed;
    logic            quotient_or_rem;
    logic            div_abort;
    logic            div_running;
    logic            div_done;
    logic [XLEN-1:0] div_result;
    logic            div_by_zero;

    modport master (
        output dividend, divisor, div_start, is_signed, quotient_or_rem, div_abort,
        input  div_running, div_done, div_result, div_by_zero
    );

    modport slave (
        input  dividend, divisor, div_start, is_signed, quotient_or_rem, div_abort,
        output div_running, div_done, div_result, div_by_zero
    );
endinterface

// File: rtl/z_core_div_step.sv
// ----------------------------------------------------------------------------
// z_core_div_step
//   One combinational radix-2 restoring division step.
//   rem_in / quo_in : partial remainder and dividend/quotient shift register
//   divisor_abs     : unsigned divisor magnitude
//   rem_out/quo_out : state after shifting {R,Q} left and trying R - divisor
// ----------------------------------------------------------------------------
module z_core_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor_abs,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // The shifted remainder is below 2*divisor, so an XLEN+1 bit difference
    // never overflows and its MSB is exactly the borrow (trial < 0).
    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor_abs};

    assign rem_out = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], ~trial[XLEN]};
endmodule

// File: rtl/z_core_seq_divider.sv
// ----------------------------------------------------------------------------
// z_core_seq_divider
//   Iterative DIV/DIVU/REM/REMU unit for the Z-Core M-extension execute stage.
//   Retires BITS_PER_CYCLE quotient bits per clock, resolves divide-by-zero,
//   signed overflow and (optionally) |a| < |b| without iterating, and can be
//   flushed at any time with div_abort.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   dif  : slave side of z_core_seq_divider_if (operands, start/abort in;
//          running, done pulse, result, div_by_zero out)
// ----------------------------------------------------------------------------
module z_core_seq_divider
    import z_core_seq_divider_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_OUT      = 1
) (
    input logic                 clk,
    input logic                 rstn,
    z_core_seq_divider_if.slave dif
);
    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    // Magnitude of a possibly-signed operand; MIN maps onto itself, which is
    // the correct unsigned magnitude 2^(XLEN-1).
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x,
                                                input logic            sgn);
        return (sgn && x[XLEN-1]) ? -x : x;
    endfunction

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q, quo_q, dvs_abs_q;
    logic             neg_quo_q, neg_rem_q, sel_quo_q, bypass_q, dbz_q;

    logic [XLEN-1:0]  dvd_abs, dvs_abs, res_fix;
    logic             accept, is_zero, is_ovf, is_early, take_fast;

    logic [BITS_PER_CYCLE:0][XLEN-1:0] rem_chain;
    logic [BITS_PER_CYCLE:0][XLEN-1:0] quo_chain;

    assign dvd_abs   = abs_val(dif.dividend, dif.is_signed);
    assign dvs_abs   = abs_val(dif.divisor, dif.is_signed);
    assign accept    = (state_q == ST_IDLE) && dif.div_start && !dif.div_abort;
    assign is_zero   = (dif.divisor == '0);
    assign is_ovf    = dif.is_signed && (dif.dividend == MIN_VAL) && (dif.divisor == '1);
    assign is_early  = (EARLY_OUT != 0) && (dvd_abs < dvs_abs);
    assign take_fast = is_zero || is_ovf || is_early;

    // Unrolled restoring steps: stage i feeds stage i+1 within one clock.
    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        z_core_div_step #(.XLEN(XLEN)) u_step (
            .rem_in      (rem_chain[i]),
            .quo_in      (quo_chain[i]),
            .divisor_abs (dvs_abs_q),
            .rem_out     (rem_chain[i+1]),
            .quo_out     (quo_chain[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = take_fast ? ST_FIXUP : ST_CALC;
            ST_CALC:  if (cnt_q == CNT_W'(1)) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (dif.div_abort) state_d = ST_IDLE;
    end

    // Sign correction; zero-divisor and MIN/-1 results are already final.
    always_comb begin
        res_fix = sel_quo_q ? quo_q : rem_q;
        if (!bypass_q) begin
            if (sel_quo_q && neg_quo_q) begin
                res_fix = -quo_q;
            end else if (!sel_quo_q && neg_rem_q) begin
                res_fix = -rem_q;
            end
        end
    end

    // --- control stage: state, handshake and registered result ---
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_IDLE;
            dif.div_running <= 1'b0;
            dif.div_done    <= 1'b0;
            dif.div_result  <= '0;
            dif.div_by_zero <= 1'b0;
        end else begin
            state_q      <= state_d;
            dif.div_done <= 1'b0;
            if (dif.div_abort) begin
                dif.div_running <= 1'b0;
            end else if (accept) begin
                dif.div_running <= 1'b1;
            end else if (state_q == ST_FIXUP) begin
                dif.div_running <= 1'b0;
                dif.div_done    <= 1'b1;
                dif.div_result  <= res_fix;
                dif.div_by_zero <= dbz_q;
            end
        end
    end

    // --- datapath stage: operand latch and iteration registers ---
    always_ff @(posedge clk) begin
        if (accept) begin
            neg_quo_q <= dif.is_signed && (dif.dividend[XLEN-1] ^ dif.divisor[XLEN-1]);
            neg_rem_q <= dif.is_signed && dif.dividend[XLEN-1];
            sel_quo_q <= dif.quotient_or_rem;
            dvs_abs_q <= dvs_abs;
            dbz_q     <= is_zero;
            bypass_q  <= is_zero || is_ovf;
            cnt_q     <= CNT_W'(STEPS);
            if (is_zero) begin
                quo_q <= '1;
                rem_q <= dif.dividend;
            end else if (is_ovf) begin
                quo_q <= dif.dividend;
                rem_q <= '0;
            end else if (is_early) begin
                quo_q <= '0;
                rem_q <= dvd_abs;
            end else begin
                quo_q <= dvd_abs;
                rem_q <= '0;
            end
        end else if (state_q == ST_CALC) begin
            rem_q <= rem_chain[BITS_PER_CYCLE];
            quo_q <= quo_chain[BITS_PER_CYCLE];
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end
endmodule
